// File: rtl/redundant_coeff_normalizer.sv
// Serial carry resolver: turns NUM_ELEMENTS redundant BIT_LEN-bit coefficients
// (one per 2*WORD_LEN slot) into a canonical radix-2^WORD_LEN integer.
module redundant_coeff_normalizer #(
  parameter int MOD_LEN               = 1024,
  parameter int WORD_LEN              = 16,
  parameter int BIT_LEN               = 17,
  parameter int REDUNDANT_ELEMENTS    = 1,
  parameter int NONREDUNDANT_ELEMENTS = MOD_LEN / WORD_LEN,
  parameter int NUM_ELEMENTS          = REDUNDANT_ELEMENTS + NONREDUNDANT_ELEMENTS,
  parameter int SQ_OUT_BITS           = NUM_ELEMENTS * WORD_LEN * 2,
  parameter int RES_LEN               = NUM_ELEMENTS * WORD_LEN
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SQ_OUT_BITS-1:0] sq_in_packed,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RES_LEN-1:0]     result,
  output logic [1:0]             carry_out,
  output logic                   fmt_err
);

  localparam int SLOT_W = 2 * WORD_LEN;
  localparam int PAD_W  = SLOT_W - BIT_LEN;
  localparam int IDX_W  = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMENTS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [1:0]           r_carry;
  logic [RES_LEN-1:0]   r_result;
  logic [1:0]           r_carry_out;
  logic                 r_fmt_err;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [BIT_LEN-1:0]   r_coef [NUM_ELEMENTS];

  logic                 w_accept;
  logic                 w_fmt_err;
  logic [BIT_LEN:0]     w_sum;
  logic [1:0]           w_carry_nxt;

  assign w_accept = (r_state == S_IDLE) && in_valid;

  // Any set bit above the coefficient field in any slot flags a malformed input.
  always_comb begin
    w_fmt_err = 1'b0;
    for (int j = 0; j < NUM_ELEMENTS; j++) begin
      w_fmt_err = w_fmt_err | (|sq_in_packed[j*SLOT_W+BIT_LEN +: PAD_W]);
    end
  end

  assign w_sum       = {1'b0, r_coef[0]} + {{(BIT_LEN-1){1'b0}}, r_carry};
  assign w_carry_nxt = w_sum[WORD_LEN +: 2];

  // Coefficients shift down so the adder always reads slot 0 (no wide mux).
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int j = 0; j < NUM_ELEMENTS; j++) begin
        r_coef[j] <= sq_in_packed[j*SLOT_W +: BIT_LEN];
      end
    end else if (r_state == S_ACCUM) begin
      for (int j = 0; j < NUM_ELEMENTS - 1; j++) begin
        r_coef[j] <= r_coef[j+1];
      end
      r_coef[NUM_ELEMENTS-1] <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_carry     <= 2'd0;
      r_result    <= '0;
      r_carry_out <= 2'd0;
      r_fmt_err   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid) begin
            r_fmt_err  <= w_fmt_err;
            r_result   <= '0;
            r_carry    <= 2'd0;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          r_result[int'(r_idx)*WORD_LEN +: WORD_LEN] <= w_sum[WORD_LEN-1:0];
          r_carry <= w_carry_nxt;
          if (r_idx == LAST_IDX) begin
            r_carry_out <= w_carry_nxt;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign fmt_err   = r_fmt_err;

endmodule

// File: tb/tb_redundant_coeff_normalizer.sv
// Bench for redundant_coeff_normalizer: directed cases plus random packets,
// checked against the integer value sum(coef_j * 2^(16*j)).
module tb_redundant_coeff_normalizer;

  localparam int W   = 16;
  localparam int BL  = 17;
  localparam int N   = 65;
  localparam int SW  = 2 * W;
  localparam int SQB = N * SW;
  localparam int RL  = N * W;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           in_valid;
  logic           in_ready;
  logic [SQB-1:0] sq_in_packed;
  logic           out_valid;
  logic           out_ready;
  logic [RL-1:0]  result;
  logic [1:0]     carry_out;
  logic           fmt_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  redundant_coeff_normalizer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sq_in_packed (sq_in_packed),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .carry_out    (carry_out),
    .fmt_err      (fmt_err)
  );

  // Reference: the packet's value as one big integer, low RL bits = result,
  // top two bits = carry_out.
  function automatic logic [RL+1:0] model_value(input logic [SQB-1:0] p);
    logic [RL+1:0] acc;
    logic [RL+1:0] term;
    acc = '0;
    for (int j = 0; j < N; j++) begin
      term = '0;
      term[BL-1:0] = p[j*SW +: BL];
      acc = acc + (term << (W * j));
    end
    return acc;
  endfunction

  function automatic logic model_fmt(input logic [SQB-1:0] p);
    logic e;
    e = 1'b0;
    for (int j = 0; j < N; j++) e = e | (|p[j*SW+BL +: SW-BL]);
    return e;
  endfunction

  function automatic logic [SQB-1:0] rand_pkt(input bit allow_fmt, input bit heavy);
    logic [SQB-1:0] p;
    logic [31:0]    s;
    p = '0;
    for (int j = 0; j < N; j++) begin
      s = $urandom;
      if (heavy) s[BL-1:0] = 17'h1FFFF - 17'($urandom_range(0, 3));
      if (!allow_fmt || ($urandom_range(0, 15) != 0)) s[31:BL] = '0;
      p[j*SW +: SW] = s;
    end
    return p;
  endfunction

  function automatic logic [SQB-1:0] fill_pkt(input logic [31:0] slot_val);
    logic [SQB-1:0] p;
    for (int j = 0; j < N; j++) p[j*SW +: SW] = slot_val;
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic [RL-1:0] obs, input logic [RL-1:0] exp);
    int bad;
    bad = 0;
    for (int j = N - 1; j >= 0; j--) if (obs[j*W +: W] !== exp[j*W +: W]) bad = j;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: digit %0d observed %h expected %h", tag, bad, obs[bad*W +: W], exp[bad*W +: W]);
    end
  endtask

  task automatic accept(input string tag, input logic [SQB-1:0] p);
    int n;
    n = 0;
    sq_in_packed = p;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_busy_in_ready"}, in_ready, 0);
    check({tag, "_busy_out_valid"}, out_valid, 0);
  endtask

  task automatic wait_out(input string tag);
    int lat;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 200);
    check({tag, "_latency"}, lat, N);
  endtask

  task automatic check_out(input string tag, input logic [SQB-1:0] p);
    logic [RL+1:0] ev;
    ev = model_value(p);
    check_result({tag, "_result"}, result, ev[RL-1:0]);
    check({tag, "_carry_out"}, carry_out, ev[RL+1:RL]);
    check({tag, "_fmt_err"}, fmt_err, model_fmt(p));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_ready_rise"}, in_ready, 1);
  endtask

  task automatic run_txn(input string tag, input logic [SQB-1:0] p);
    accept(tag, p);
    wait_out(tag);
    check_out(tag, p);
    handshake(tag);
  endtask

  logic [SQB-1:0] pkt;
  logic [RL+1:0]  ev;

  initial begin
    reset_n      = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    sq_in_packed = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check_result("rst_result", result, '0);
    check("rst_carry_out", carry_out, 0);
    check("rst_fmt_err", fmt_err, 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    run_txn("zero", '0);

    pkt = '0;
    pkt[31:0] = 32'h0001FFFF;
    run_txn("slot0", pkt);
    check("slot0_digit1", result[2*W-1:W], 32'h1);

    pkt = fill_pkt(32'h0001FFFF);
    run_txn("maxcarry", pkt);
    check("maxcarry_carry2", carry_out, 2);
    check("maxcarry_digit2", result[3*W-1:2*W], 32'h1);

    pkt = '0;
    pkt[7*SW +: SW] = 32'h00020000;
    run_txn("fmt", pkt);
    check("fmt_flag_set", fmt_err, 1);
    pkt = rand_pkt(1'b0, 1'b0);
    run_txn("fmt_clear", pkt);

    // Backpressure: hold the result while in_valid pulses are offered.
    pkt = rand_pkt(1'b0, 1'b1);
    ev  = model_value(pkt);
    accept("bp", pkt);
    wait_out("bp");
    check_out("bp", pkt);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      sq_in_packed = rand_pkt(1'b1, 1'b0);
      @(posedge clk); #1;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_in_ready", in_ready, 0);
      check_result("bp_hold_result", result, ev[RL-1:0]);
      check("bp_hold_carry", carry_out, ev[RL+1:RL]);
    end
    in_valid = 1'b0;
    handshake("bp");
    pkt = rand_pkt(1'b1, 1'b0);
    run_txn("bp_next", pkt);

    // Asynchronous reset partway through accumulation.
    pkt = fill_pkt(32'h0001FFFF);
    accept("abort", pkt);
    repeat (30) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check_result("abort_result", result, '0);
    check("abort_carry_out", carry_out, 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    check("abort_no_valid", out_valid, 0);
    pkt = '0;
    pkt[31:0] = 32'h0001FFFF;
    run_txn("after_abort", pkt);

    for (int t = 0; t < 6; t++) begin
      pkt = rand_pkt(t[0], t[1]);
      run_txn($sformatf("rand%0d", t), pkt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
